// File: rtl/clk_en_pkg.sv
// clk_en_pkg: shared clock-rate constants and channel assignments for the clock-enable generator.
package clk_en_pkg;
    localparam int CLK_FREQ_HZ        = 40_000_000;
    localparam int DIV_W              = 26;
    localparam int DIV_1HZ            = CLK_FREQ_HZ;
    localparam int DIV_DEBOUNCE_100HZ = CLK_FREQ_HZ / 100;
    localparam int DIV_SCAN_1KHZ      = CLK_FREQ_HZ / 1000;
    localparam int CH_SCAN            = 0;
    localparam int CH_1HZ             = 1;
    localparam int CH_DEBOUNCE        = 2;
    localparam int CH_AUDIO           = 3;
endpackage

// File: rtl/clk_en_ch.sv
// clk_en_ch: one divider channel with glitch-free divisor update, tick pulse and square wave.
module clk_en_ch import clk_en_pkg::*; #(
    parameter int DIV_W   = 26,
    parameter int DIV_RST = 2
) (
    input  logic             clk_40M,
    input  logic             rst,
    input  logic             en,
    input  logic             we,
    input  logic [DIV_W-1:0] wdiv,
    input  logic             restart,
    output logic             tick,
    output logic             sq,
    output logic             pend
);
    logic [DIV_W-1:0] cnt_q, cnt_d, dact_q, dact_d, pdiv_q, pdiv_d, dnext;
    logic             pend_q, pend_d, tick_q, tick_d, sq_q, sq_d, reload;
    // Reload on disable, restart or terminal count; a write lands in pend after that reload is taken
    always_comb begin
        dnext  = pend_q ? pdiv_q : dact_q;
        reload = !en || restart || cnt_q == '0;
        cnt_d  = reload ? dnext - 1'b1 : cnt_q - 1'b1;
        dact_d = reload ? dnext : dact_q;
        pend_d = we || (pend_q && !reload);
        pdiv_d = we ? ((wdiv == '0) ? DIV_W'(1) : wdiv) : pdiv_q;
        tick_d = en && !restart && cnt_q == '0;
        sq_d   = !en ? sq_q : restart ? 1'b0 : sq_q ^ (cnt_q == '0);
    end
    // Channel state registers
    always_ff @(posedge clk_40M) begin
        if (rst) begin
            cnt_q  <= DIV_W'(DIV_RST - 1);
            dact_q <= DIV_W'(DIV_RST);
            pdiv_q <= DIV_W'(DIV_RST);
            pend_q <= 1'b0;
            tick_q <= 1'b0;
            sq_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dact_q <= dact_d;
            pdiv_q <= pdiv_d;
            pend_q <= pend_d;
            tick_q <= tick_d;
            sq_q   <= sq_d;
        end
    end
    assign tick = tick_q;
    assign sq   = sq_q;
    assign pend = pend_q;
endmodule

// File: rtl/clk_en_gen.sv
// clk_en_gen: NUM_CH programmable clock-enable dividers with square waves and a display-scan counter.
// Define CLK_EN_GEN_PHASE_SYNC_EN to let the sync strobe restart all enabled channels in phase.
module clk_en_gen import clk_en_pkg::*; #(
    parameter int NUM_CH  = 4,
    parameter int DIV_W   = clk_en_pkg::DIV_W,
    parameter int DIV_RST = 2,
    parameter int SCAN_W  = 2,
    parameter int SCAN_CH = clk_en_pkg::CH_SCAN,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_40M,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              sync,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq,
    output logic [NUM_CH-1:0] pend,
    output logic [SCAN_W-1:0] scan_cnt
);
    logic              restart;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
`ifdef CLK_EN_GEN_PHASE_SYNC_EN
    assign restart = sync;
`else
    logic unused_sync;
    assign unused_sync = sync;
    assign restart     = 1'b0;
`endif
    // Out-of-range cfg_ch matches no channel, so such writes fall through
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_en_ch #(.DIV_W(DIV_W), .DIV_RST(DIV_RST)) u_ch (
            .clk_40M (clk_40M),
            .rst     (rst),
            .en      (ch_en[i]),
            .we      (cfg_we && cfg_ch == CH_W'(i)),
            .wdiv    (cfg_div),
            .restart (restart),
            .tick    (tick[i]),
            .sq      (sq[i]),
            .pend    (pend[i])
        );
    end
    // Scan index advances once per scan-channel tick, wrapping naturally
    always_comb scan_cnt_d = tick[SCAN_CH] ? scan_cnt_q + 1'b1 : scan_cnt_q;
    // Scan index register
    always_ff @(posedge clk_40M) begin
        if (rst) scan_cnt_q <= '0;
        else     scan_cnt_q <= scan_cnt_d;
    end
    assign scan_cnt = scan_cnt_q;
endmodule

// File: tb/tb_clk_en_gen.sv
// tb_clk_en_gen: table vectors, directed corner sequences and a random run against a tick-schedule model.
module tb_clk_en_gen;
    logic        clk_40M;
    logic        rst, cfg_we, sync;
    logic [3:0]  ch_en, tick, sq, pend;
    logic [1:0]  cfg_ch, scan_cnt;
    logic [25:0] cfg_div;
    logic [2:0]  ch_en3, tick3, sq3, pend3;
    logic        cfg_we3;
    logic [1:0]  cfg_ch3, scan3;
    logic [25:0] cfg_div3;

    clk_en_gen dut (.clk_40M(clk_40M), .rst(rst), .ch_en(ch_en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .sync(sync), .tick(tick), .sq(sq), .pend(pend), .scan_cnt(scan_cnt));
    clk_en_gen #(.NUM_CH(3)) dut3 (.clk_40M(clk_40M), .rst(rst), .ch_en(ch_en3), .cfg_we(cfg_we3),
        .cfg_ch(cfg_ch3), .cfg_div(cfg_div3), .sync(sync), .tick(tick3), .sq(sq3), .pend(pend3),
        .scan_cnt(scan3));

    initial clk_40M = 1'b0;
    always #5 clk_40M = ~clk_40M;

    int n_chk = 0, n_pass = 0, cyc = 0;
    bit mchk = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference model: each channel keeps the absolute cycle of its next tick
    int m_d[4], m_pv[4], m_nxt[4], m_scan;
    bit m_pend[4], m_tick[4], m_sq[4];
    bit fire, again;
    always @(posedge clk_40M) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_d[i] = 2; m_pend[i] = 0; m_tick[i] = 0; m_sq[i] = 0; m_nxt[i] = cyc + 3;
            end
            m_scan = 0;
        end else begin
            if (m_tick[0]) m_scan = (m_scan + 1) % 4;
            for (int i = 0; i < 4; i++) begin
                fire = 0;
                again = 0;
                if (!ch_en[i]) again = 1;
`ifdef CLK_EN_GEN_PHASE_SYNC_EN
                else if (sync) begin again = 1; m_sq[i] = 0; end
`endif
                else if (m_nxt[i] == cyc + 1) begin fire = 1; again = 1; m_sq[i] = !m_sq[i]; end
                if (again) begin
                    if (m_pend[i]) m_d[i] = m_pv[i];
                    m_pend[i] = 0;
                    m_nxt[i] = cyc + 1 + m_d[i];
                end
                m_tick[i] = fire;
                if (cfg_we && int'(cfg_ch) == i) begin
                    m_pv[i] = (cfg_div == 26'd0) ? 1 : int'(cfg_div);
                    m_pend[i] = 1;
                end
            end
        end
        cyc++;
    end

    logic [3:0] et, es, ep;
    always @(negedge clk_40M) if (mchk) begin
        for (int i = 0; i < 4; i++) begin et[i] = m_tick[i]; es[i] = m_sq[i]; ep[i] = m_pend[i]; end
        chk("model_tick", 32'(tick), 32'(et));
        chk("model_sq", 32'(sq), 32'(es));
        chk("model_pend", 32'(pend), 32'(ep));
        chk("model_scan", 32'(scan_cnt), 32'(m_scan));
    end

    task automatic step();
        @(posedge clk_40M);
        @(negedge clk_40M);
    endtask

    task automatic do_reset();
        rst = 1; ch_en = 4'b0; cfg_we = 0; sync = 0; cfg_we3 = 0;
        step();
        rst = 0;
    endtask

    typedef struct {
        logic [3:0]  en;
        logic        we;
        logic [1:0]  ch;
        logic [25:0] div;
        logic [3:0]  tk, sqv, pd;
        logic [1:0]  sc;
    } vec_t;
    vec_t tbl[9];

    initial begin
        tbl[0] = '{4'b0001, 1'b0, 2'd0, 26'd0, 4'b0000, 4'b0000, 4'b0000, 2'd0};
        tbl[1] = '{4'b0001, 1'b0, 2'd0, 26'd0, 4'b0001, 4'b0001, 4'b0000, 2'd0};
        tbl[2] = '{4'b0001, 1'b0, 2'd0, 26'd0, 4'b0000, 4'b0001, 4'b0000, 2'd1};
        tbl[3] = '{4'b0001, 1'b0, 2'd0, 26'd0, 4'b0001, 4'b0000, 4'b0000, 2'd1};
        tbl[4] = '{4'b0001, 1'b0, 2'd0, 26'd0, 4'b0000, 4'b0000, 4'b0000, 2'd2};
        tbl[5] = '{4'b0001, 1'b0, 2'd0, 26'd0, 4'b0001, 4'b0001, 4'b0000, 2'd2};
        tbl[6] = '{4'b0001, 1'b0, 2'd0, 26'd0, 4'b0000, 4'b0001, 4'b0000, 2'd3};
        tbl[7] = '{4'b0001, 1'b1, 2'd1, 26'd5, 4'b0001, 4'b0000, 4'b0010, 2'd3};
        tbl[8] = '{4'b0001, 1'b0, 2'd0, 26'd0, 4'b0000, 4'b0000, 4'b0000, 2'd0};
        rst = 1; ch_en = 4'b0; cfg_we = 0; cfg_ch = 2'd0; cfg_div = 26'd0; sync = 0;
        ch_en3 = 3'b0; cfg_we3 = 0; cfg_ch3 = 2'd0; cfg_div3 = 26'd5;
        repeat (3) step();
        mchk = 1'b1;
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_sq", 32'(sq), 32'd0);
        chk("rst_pend", 32'(pend), 32'd0);
        chk("rst_scan", 32'(scan_cnt), 32'd0);
        rst = 0;
        foreach (tbl[k]) begin
            ch_en = tbl[k].en; cfg_we = tbl[k].we; cfg_ch = tbl[k].ch; cfg_div = tbl[k].div;
            step();
            chk("tbl_tick", 32'(tick), 32'(tbl[k].tk));
            chk("tbl_sq", 32'(sq), 32'(tbl[k].sqv));
            chk("tbl_pend", 32'(pend), 32'(tbl[k].pd));
            chk("tbl_scan", 32'(scan_cnt), 32'(tbl[k].sc));
        end
        // Divisor 2 -> 5 on a running channel
        do_reset();
        for (int k = 0; k < 15; k++) begin
            ch_en = 4'b0010; cfg_we = (k == 2); cfg_ch = 2'd1; cfg_div = 26'd5;
            step();
            chk("d5_tick", 32'(tick[1]), 32'(k == 1 || k == 3 || k == 8 || k == 13));
            if (k == 2 || k == 3) chk("d5_pend", 32'(pend[1]), 32'(k == 2));
        end
        // Divisor 0 behaves as 1
        do_reset();
        for (int k = 0; k < 8; k++) begin
            ch_en = (k < 2) ? 4'b0000 : 4'b0100; cfg_we = (k == 0); cfg_ch = 2'd2; cfg_div = 26'd0;
            step();
            if (k >= 2) begin
                chk("d0_tick", 32'(tick[2]), 32'd1);
                chk("d0_sq", 32'(sq[2]), 32'(k % 2 == 0));
            end
        end
        // Last write wins, write on reload waits, out-of-range channel ignored
        do_reset();
        for (int k = 0; k < 27; k++) begin
            ch_en = (k < 2) ? 4'b0000 : 4'b1000;
            cfg_we = (k == 0 || k == 3 || k == 4 || k == 14); cfg_ch = 2'd3;
            cfg_div = 26'((k == 0) ? 4 : (k == 3) ? 7 : (k == 4) ? 9 : 3);
            cfg_we3 = (k == 6 || k == 8); cfg_ch3 = (k == 6) ? 2'd3 : 2'd2;
            step();
            chk("lw_tick", 32'(tick[3]), 32'(k == 5 || k == 14 || k == 23 || k == 26));
            if (k == 3 || k == 5 || k == 14 || k == 22 || k == 23)
                chk("lw_pend", 32'(pend[3]), 32'(k == 3 || k == 14 || k == 22));
            if (k >= 6 && k <= 8) chk("oor_pend", 32'(pend3), 32'((k == 8) ? 3'b100 : 3'b000));
        end
        cfg_we3 = 0;
        // Reset coinciding with a write mid-count
        do_reset();
        for (int k = 0; k < 10; k++) begin
            rst = (k == 5); ch_en = 4'b0001; cfg_we = (k == 5); cfg_ch = 2'd1; cfg_div = 26'd5;
            step();
            if (k == 4) chk("pre_rst_scan", 32'(scan_cnt), 32'd2);
            if (k == 5) begin
                chk("mid_rst_tick", 32'(tick), 32'd0);
                chk("mid_rst_sq", 32'(sq), 32'd0);
                chk("mid_rst_pend", 32'(pend), 32'd0);
                chk("mid_rst_scan", 32'(scan_cnt), 32'd0);
            end
            if (k > 5) chk("post_rst_tick", 32'(tick[0]), 32'(k == 7 || k == 9));
        end
        rst = 0; cfg_we = 0;
`ifdef CLK_EN_GEN_PHASE_SYNC_EN
        do_reset();
        for (int k = 0; k < 18; k++) begin
            ch_en = (k < 3) ? 4'b0000 : (k < 5) ? 4'b0001 : 4'b0011;
            cfg_we = (k < 2); cfg_ch = 2'(k); cfg_div = 26'd4; sync = (k == 9);
            step();
            if (k >= 6) chk("sync_tick", 32'(tick[1:0]),
                32'((k == 6) ? 2'b01 : (k == 8) ? 2'b10 : (k == 13 || k == 17) ? 2'b11 : 2'b00));
            if (k == 9) chk("sync_sq", 32'(sq[1:0]), 32'd0);
        end
`else
        do_reset();
        for (int k = 0; k < 6; k++) begin
            ch_en = 4'b0001; cfg_we = 0; sync = 1;
            step();
            chk("nosync_tick", 32'(tick[0]), 32'(k == 1 || k == 3 || k == 5));
        end
`endif
        sync = 0;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(299) == 0);
            if ($urandom_range(15) == 0) ch_en = 4'($urandom);
            cfg_we = ($urandom_range(3) == 0);
            cfg_ch = 2'($urandom);
            cfg_div = 26'($urandom_range(7));
            sync = ($urandom_range(19) == 0);
            step();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
